// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and
// the instruction queue head presented to the IF/ID register.
interface fetch_prefetch_queue_if;
   logic        mem_req;
   logic [6:0]  mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [6:0]  inst_pc_inc;
   logic        deq_ready;

   modport master (
      output mem_req, mem_addr, inst_valid, inst_data, inst_pc_inc,
      input  mem_gnt, mem_rvalid, mem_rdata, deq_ready
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, inst_data, inst_pc_inc,
      output mem_gnt, mem_rvalid, mem_rdata, deq_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue with credit-based memory requests and redirect flush.
// Define FETCH_PERF_EN to add the saturating drop_count output.
module fetch_prefetch_queue #(
   parameter int         DEPTH    = 4,
   parameter int         MAX_OUT  = 2,
   parameter logic [6:0] PC_START = 7'h00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [6:0]            redirect_pc,
`ifdef FETCH_PERF_EN
   output logic [7:0]            drop_count,
`endif
   fetch_prefetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [6:0]  pc_inc;
   } entry_t;

   state_t          state, state_nx;
   logic [6:0]      fetch_pc;
   entry_t          q_mem [DEPTH];
   logic [AW-1:0]   q_rd, q_wr;
   logic [CW-1:0]   count;
   logic [6:0]      tag_mem [MAX_OUT];
   logic [TW-1:0]   tag_rd, tag_wr;
   logic [OW-1:0]   live;
   logic [OW-1:0]   drop_cnt;
   logic [OW-1:0]   rd_drop;
   logic [SW-1:0]   inflight, credit;
   logic            req, grant, rv, drop_rsp, take_rsp, head_valid, pop;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Dropped slots still occupy memory-side credit until their data returns.
   assign inflight = SW'(live) + SW'(drop_cnt);
   assign credit   = SW'(count) + inflight;
   assign req      = !reset && !redirect_valid &&
                     (credit < SW'(DEPTH)) && (inflight < SW'(MAX_OUT));
   assign grant    = req && bus.mem_gnt;
   assign rv       = bus.mem_rvalid;
   assign drop_rsp = rv && (drop_cnt != '0);
   assign take_rsp = rv && (drop_cnt == '0) && (live != '0);
   assign head_valid = !reset && (count != '0);
   assign pop      = head_valid && bus.deq_ready;
   // Redirect converts all in-flight slots to drops, less one already returning now.
   assign rd_drop  = OW'(inflight - SW'(rv && (inflight != '0)));

   assign bus.mem_req     = req;
   assign bus.mem_addr    = reset ? PC_START : fetch_pc;
   assign bus.inst_valid  = head_valid;
   assign bus.inst_data   = head_valid ? q_mem[q_rd].data   : '0;
   assign bus.inst_pc_inc = head_valid ? q_mem[q_rd].pc_inc : '0;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = RUN;
         RUN:   if (redirect_valid && rd_drop != '0) state_nx = DRAIN;
         DRAIN: begin
            if (redirect_valid)
               state_nx = (rd_drop != '0) ? DRAIN : RUN;
            else if (drop_cnt == '0 || (drop_cnt == OW'(1) && drop_rsp))
               state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= PC_START;
         q_rd     <= '0;
         q_wr     <= '0;
         count    <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
         live     <= '0;
         drop_cnt <= '0;
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & 7'h7C;
            q_rd     <= '0;
            q_wr     <= '0;
            count    <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            live     <= '0;
            drop_cnt <= rd_drop;
         end else begin
            if (grant) begin
               fetch_pc <= fetch_pc + 7'd4;
               tag_wr   <= tag_inc(tag_wr);
            end
            if (take_rsp) begin
               q_wr   <= q_wr + 1'b1;
               tag_rd <= tag_inc(tag_rd);
            end
            if (pop)      q_rd     <= q_rd + 1'b1;
            if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
            live  <= live + OW'(grant) - OW'(take_rsp);
            count <= count + CW'(take_rsp) - CW'(pop);
         end
      end
   end

   // Storage arrays carry no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!reset && !redirect_valid) begin
         if (grant) tag_mem[tag_wr] <= fetch_pc;
         if (take_rsp) q_mem[q_wr] <= '{data: bus.mem_rdata, pc_inc: tag_mem[tag_rd] + 7'd4};
      end
   end

`ifdef FETCH_PERF_EN
   logic discard;
   assign discard = rv && (redirect_valid || drop_cnt != '0 || live == '0);

   always_ff @(posedge clk) begin
      if (reset)
         drop_count <= 8'h00;
      else if (discard && drop_count != 8'hFF)
         drop_count <= drop_count + 8'h01;
   end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: in-order random-latency memory
// plus a queue-based reference model of the fetch/drop rules.
module tb_fetch_prefetch_queue;
   localparam int         DEPTH    = 4;
   localparam int         MAX_OUT  = 2;
   localparam logic [6:0] PC_START = 7'h00;

   logic       clk = 1'b0;
   logic       reset;
   logic       redirect_valid;
   logic [6:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [7:0] drop_count;
`endif

   fetch_prefetch_queue_if bus();

   fetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .PC_START(PC_START)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_EN
      .drop_count     (drop_count),
`endif
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic [6:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] data; logic [6:0] pcinc; } ent_t;

   logic [31:0] mem_img [128];
   mreq_t       mem_q [$];
   ent_t        mq [$];
   logic [6:0]  tags [$];
   int          drop, perf, cyc;
   logic [6:0]  mpc;
   int          n_chk, n_err;
   int          k_gnt, k_deq, k_rv, lat_lo, lat_hi;
   logic        seen_valid, seen_req;
   logic [6:0]  seen_pcinc, seen_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit redir, input logic [6:0] rpc);
      bit          gnt, deq, rv, exp_req, popped;
      logic [31:0] rd;
      logic [6:0]  t;
      int          inflight, due;
      @(negedge clk);
      reset = rst; redirect_valid = redir; redirect_pc = rpc;
      gnt = ($urandom_range(99) < k_gnt);
      deq = ($urandom_range(99) < k_deq);
      rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < k_rv);
      rd  = rv ? mem_img[mem_q[0].addr] : $urandom;
      bus.mem_gnt = gnt; bus.deq_ready = deq; bus.mem_rvalid = rv; bus.mem_rdata = rd;
      #1;
      seen_valid = bus.inst_valid; seen_pcinc = bus.inst_pc_inc;
      seen_req = bus.mem_req; seen_addr = bus.mem_addr;
      inflight = tags.size() + drop;
      exp_req  = !rst && !redir && (mq.size() + inflight < DEPTH) && (inflight < MAX_OUT);
      if (rst) begin
         chk("rst_inst_valid", bus.inst_valid, 0);
         chk("rst_inst_data", bus.inst_data, 0);
         chk("rst_pc_inc", bus.inst_pc_inc, 0);
         chk("rst_mem_req", bus.mem_req, 0);
         chk("rst_mem_addr", bus.mem_addr, PC_START);
      end else begin
         chk("mem_req", bus.mem_req, exp_req);
         chk("mem_addr", bus.mem_addr, mpc);
         chk("inst_valid", bus.inst_valid, mq.size() > 0);
         if (mq.size() > 0) begin
            chk("inst_data", bus.inst_data, mq[0].data);
            chk("inst_pc_inc", bus.inst_pc_inc, mq[0].pcinc);
         end
      end
`ifdef FETCH_PERF_EN
      if (!rst) chk("drop_count", drop_count, perf);
`endif
      // environment memory: in-order, latency >= 1 cycle after grant
      if (rv) void'(mem_q.pop_front());
      if (bus.mem_req && gnt) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (mem_q.size() > 0 && mem_q[mem_q.size()-1].due > due) due = mem_q[mem_q.size()-1].due;
         mem_q.push_back('{addr: bus.mem_addr, due: due});
      end
      // reference model
      if (rst) begin
         mq.delete(); tags.delete(); drop = 0; perf = 0; mpc = PC_START;
      end else if (redir) begin
         if (rv) perf++;
         drop = inflight - ((rv && inflight > 0) ? 1 : 0);
         mq.delete(); tags.delete();
         mpc = rpc & 7'h7C;
      end else begin
         popped = (mq.size() > 0) && deq;
         if (rv) begin
            if (drop > 0) begin drop--; perf++; end
            else if (tags.size() > 0) begin
               t = tags.pop_front();
               mq.push_back('{data: rd, pcinc: t + 7'd4});
            end else perf++;
         end
         if (popped) void'(mq.pop_front());
         if (exp_req && gnt) begin tags.push_back(mpc); mpc = mpc + 7'd4; end
      end
      if (perf > 255) perf = 255;
      @(posedge clk);
      cyc++;
   endtask

   task automatic run_until_valid(input string tag, input logic [6:0] exp_pcinc);
      int n;
      n = 0;
      do begin step(0, 0, 7'h00); n++; end while (!seen_valid && n < 12);
      chk({tag, "_valid_seen"}, seen_valid, 1);
      chk(tag, seen_pcinc, exp_pcinc);
   endtask

   initial begin
      n_chk = 0; n_err = 0; cyc = 0; drop = 0; perf = 0; mpc = PC_START;
      foreach (mem_img[i]) mem_img[i] = $urandom;
      reset = 1; redirect_valid = 0; redirect_pc = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.deq_ready = 0;
      k_gnt = 100; k_deq = 100; k_rv = 100; lat_lo = 1; lat_hi = 1;

      repeat (2) step(1, 0, 7'h00);

      // fetch from reset address, first entry at 00 -> pc_inc 04
      run_until_valid("first_pc_inc", 7'h04);
      repeat (6) step(0, 0, 7'h00);

      // back-pressure: queue fills, requests stop, one pop reopens credit
      k_deq = 0;
      repeat (10) step(0, 0, 7'h00);
      chk("full_valid", seen_valid, 1);
      chk("full_req_off", seen_req, 0);
      k_deq = 100; step(0, 0, 7'h00);
      k_deq = 0;   step(0, 0, 7'h00);
      chk("req_after_pop", seen_req, 1);

      // redirect with two requests in flight
      k_deq = 100; lat_lo = 3; lat_hi = 3;
      step(0, 1, 7'h40);
      for (int i = 0; i < 20 && tags.size() != 2; i++) step(0, 0, 7'h00);
      step(0, 1, 7'h23);
      step(0, 0, 7'h00);
      chk("redirect_addr", seen_addr, 7'h20);
      run_until_valid("redirect_pc_inc", 7'h24);
      repeat (4) step(0, 0, 7'h00);

      // address wrap at 7'h7C
      lat_lo = 1; lat_hi = 1;
      step(0, 1, 7'h7E);
      step(0, 0, 7'h00);
      chk("wrap_addr_7c", seen_addr, 7'h7C);
      step(0, 0, 7'h00);
      chk("wrap_addr_00", seen_addr, 7'h00);
      run_until_valid("wrap_pc_inc", 7'h00);

      // grant withheld: address holds
      k_gnt = 0;
      step(0, 1, 7'h10);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 7'h00);
         chk("hold_addr", seen_addr, 7'h10);
         chk("hold_req", seen_req, 1);
      end
      k_gnt = 100;
      repeat (6) step(0, 0, 7'h00);

      // reset with entries queued and a response still pending
      k_deq = 0; lat_lo = 2; lat_hi = 2;
      step(0, 1, 7'h00);
      for (int i = 0; i < 20 && mq.size() < 3; i++) step(0, 0, 7'h00);
      step(1, 0, 7'h00);
      k_gnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 7'h00);
         chk("post_reset_empty", seen_valid, 0);
      end
      k_gnt = 100; k_deq = 100; lat_lo = 1;
      repeat (6) step(0, 0, 7'h00);

      // randomized traffic
      k_gnt = 70; k_deq = 60; k_rv = 80; lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(999);
         if (r < 5)       step(1, 0, 7'h00);
         else if (r < 45) step(0, 1, 7'($urandom));
         else             step(0, 0, 7'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
